// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory read/write port between fetch and LSU, one access per two cycles.
// Define MEM_ARB_LSU_PRIORITY_EN for fixed LSU priority instead of round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [1:0]        lsu_len,
    input  logic              lsu_signed,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_ack,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [ADDR_W-1:0] MEM_read_address,
    output logic [1:0]        MEM_read_length,
    output logic              MEM_read_signed,
    input  logic [DATA_W-1:0] MEM_read_data,
    output logic [ADDR_W-1:0] MEM_write_address,
    output logic [1:0]        MEM_write_length,
    output logic [DATA_W-1:0] MEM_write_data,
    output logic              busy
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t            state;
    logic              last_grant;
    logic              sel_lsu;
    logic [ADDR_W-1:0] l_addr;
    logic              l_we;
    logic [1:0]        l_len;
    logic              l_signed;
    logic [DATA_W-1:0] l_wdata;
    logic              idle, pick_lsu, store, load;

    assign idle = state == IDLE && !SYS_reset;
`ifdef MEM_ARB_LSU_PRIORITY_EN
    assign pick_lsu = lsu_req;
`else
    // last_grant: 0 = IF, 1 = LSU; on contention the other side wins
    assign pick_lsu = lsu_req && (!if_req || !last_grant);
`endif
    assign if_ack  = idle && if_req && !pick_lsu;
    assign lsu_ack = idle && pick_lsu;
    assign busy    = state == SERVE;
    assign store   = busy && sel_lsu && l_we;
    assign load    = busy && sel_lsu && !l_we;

    assign MEM_read_address  = busy && !store ? l_addr : '0;
    assign MEM_read_length   = load ? l_len : (busy && !sel_lsu ? 2'b11 : 2'b00);
    assign MEM_read_signed   = load && l_signed;
    assign MEM_write_address = store ? l_addr : '0;
    // a reset landing on SERVE must abort the write in that same cycle
    assign MEM_write_length  = store && !SYS_reset ? l_len : 2'b00;
    assign MEM_write_data    = store ? l_wdata : '0;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state         <= IDLE;
            last_grant    <= 1'b0;
            sel_lsu       <= 1'b0;
            l_addr        <= '0;
            l_we          <= 1'b0;
            l_len         <= 2'b00;
            l_signed      <= 1'b0;
            l_wdata       <= '0;
            if_rsp_valid  <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            if_rdata      <= '0;
            lsu_rdata     <= '0;
        end else begin
            if_rsp_valid  <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            if (state == IDLE) begin
                if (if_ack || lsu_ack) begin
                    state      <= SERVE;
                    last_grant <= lsu_ack;
                    sel_lsu    <= lsu_ack;
                    l_addr     <= lsu_ack ? lsu_addr : if_addr;
                    l_we       <= lsu_ack && lsu_we;
                    l_len      <= lsu_ack ? lsu_len : 2'b11;
                    l_signed   <= lsu_ack && lsu_signed;
                    l_wdata    <= lsu_ack ? lsu_wdata : '0;
                end
            end else begin
                state <= IDLE;
                if (sel_lsu) begin
                    lsu_rsp_valid <= 1'b1;
                    lsu_rdata     <= l_we || l_len == 2'b00 ? '0 : MEM_read_data;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rdata     <= MEM_read_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a response scoreboard and a byte-array memory model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack, if_rsp_valid;
    logic [31:0] if_rdata;
    logic        lsu_req = 1'b0, lsu_we = 1'b0, lsu_signed = 1'b0;
    logic [1:0]  lsu_len = 2'b00;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic        lsu_ack, lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic [31:0] MEM_read_address, MEM_read_data, MEM_write_address, MEM_write_data;
    logic [1:0]  MEM_read_length, MEM_write_length;
    logic        MEM_read_signed, busy;

    logic [7:0]  mem [0:1023];
    logic [9:0]  ra, wa;
    logic [31:0] exp_if[$], exp_lsu[$];
    int          n_vec = 0, n_err = 0;

    mem_port_arbiter dut (
        .SYS_clk(clk), .SYS_reset(SYS_reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_len(lsu_len), .lsu_signed(lsu_signed),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_ack(lsu_ack),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .MEM_read_address(MEM_read_address), .MEM_read_length(MEM_read_length),
        .MEM_read_signed(MEM_read_signed), .MEM_read_data(MEM_read_data),
        .MEM_write_address(MEM_write_address), .MEM_write_length(MEM_write_length),
        .MEM_write_data(MEM_write_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // little-endian byte memory, combinational read, write at the clock edge
    always_comb begin
        ra = MEM_read_address[9:0];
        case (MEM_read_length)
            2'b01:   MEM_read_data = {{24{MEM_read_signed & mem[ra][7]}}, mem[ra]};
            2'b10:   MEM_read_data = {{16{MEM_read_signed & mem[ra+10'd1][7]}}, mem[ra+10'd1], mem[ra]};
            2'b11:   MEM_read_data = {mem[ra+10'd3], mem[ra+10'd2], mem[ra+10'd1], mem[ra]};
            default: MEM_read_data = '0;
        endcase
    end

    assign wa = MEM_write_address[9:0];
    always @(posedge clk) begin
        if (MEM_write_length != 2'b00) begin
            mem[wa] <= MEM_write_data[7:0];
            if (MEM_write_length[1]) mem[wa+10'd1] <= MEM_write_data[15:8];
            if (MEM_write_length == 2'b11) begin
                mem[wa+10'd2] <= MEM_write_data[23:16];
                mem[wa+10'd3] <= MEM_write_data[31:24];
            end
        end
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (if_rsp_valid) begin
            if (exp_if.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL if_rsp_unexpected: got rdata %h expected no response", if_rdata);
            end else check("if_rdata", if_rdata, exp_if.pop_front());
        end
        if (lsu_rsp_valid) begin
            if (exp_lsu.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL lsu_rsp_unexpected: got rdata %h expected no response", lsu_rdata);
            end else check("lsu_rdata", lsu_rdata, exp_lsu.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        SYS_reset = 1'b1;
        step();
        step();
        SYS_reset = 1'b0;
    endtask

    task automatic lsu_op(input logic we, input logic [1:0] len, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rexp);
        bit acked = 0;
        step();
        lsu_req = 1'b1; lsu_we = we; lsu_len = len; lsu_signed = sg; lsu_addr = a; lsu_wdata = wd;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(negedge clk);
            if (lsu_ack) acked = 1;
            else step();
        end
        if (!acked) begin
            n_vec++; n_err++;
            $display("FAIL lsu_ack_timeout: got no ack expected ack at %h", a);
            lsu_req = 1'b0;
        end else begin
            exp_lsu.push_back(rexp);
            step();
            lsu_req = 1'b0;
            @(negedge clk);
            check("serve_busy", busy, 1);
            check("serve_wlen", MEM_write_length, we ? len : 2'b00);
            check("serve_rlen", MEM_read_length, we ? 2'b00 : len);
            @(negedge clk);
            check("rsp_wlen", MEM_write_length, 0);
            check("lsu_rsp_valid", lsu_rsp_valid, 1);
        end
    endtask

    logic [1:0] exp_grant [0:7];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]} = 32'hDEADBEEF;
        {mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]} = 32'h11223344;
`ifdef MEM_ARB_LSU_PRIORITY_EN
        exp_grant = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
`else
        exp_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
`endif
        do_reset();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_acks", {if_ack, lsu_ack}, 0);
        check("rst_rsp", {if_rsp_valid, lsu_rsp_valid}, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_lsu_rdata", lsu_rdata, 0);
        check("rst_mem_len", {MEM_read_length, MEM_write_length}, 0);

        step();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        check("if_ack_c0", if_ack, 1);
        if (if_ack) exp_if.push_back(32'hDEADBEEF);
        step();
        if_req = 1'b0;
        @(negedge clk);
        check("if_busy_c1", busy, 1);
        check("if_raddr_c1", MEM_read_address, 32'h100);
        check("if_rlen_c1", MEM_read_length, 2'b11);
        check("if_rsigned_c1", MEM_read_signed, 0);
        @(negedge clk);
        check("if_rsp_c2", if_rsp_valid, 1);

        lsu_op(1, 2'b11, 0, 32'h200, 32'h12345678, 0);
        lsu_op(0, 2'b01, 1, 32'h203, 0, 32'h00000012);
        lsu_op(1, 2'b01, 0, 32'h203, 32'h00000080, 0);
        lsu_op(0, 2'b01, 1, 32'h203, 0, 32'hFFFFFF80);
        lsu_op(0, 2'b10, 0, 32'h202, 0, 32'h00008034);
        lsu_op(0, 2'b10, 1, 32'h202, 0, 32'hFFFF8034);
        lsu_op(1, 2'b00, 0, 32'h200, 32'hAAAAAAAA, 0);
        lsu_op(0, 2'b11, 0, 32'h200, 0, 32'h80345678);

        step();
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_len = 2'b11; lsu_addr = 32'h300; lsu_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("abort_ack", lsu_ack, 1);
        step();
        lsu_req = 1'b0; SYS_reset = 1'b1;
        @(negedge clk);
        check("abort_wlen", MEM_write_length, 0);
        step();
        SYS_reset = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 0);
        check("abort_no_rsp", lsu_rsp_valid, 0);
        lsu_op(0, 2'b11, 0, 32'h300, 0, 32'h11223344);

        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_len = 2'b11; lsu_signed = 1'b0; lsu_addr = 32'h200;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("grant_%0d", i), {if_ack, lsu_ack}, exp_grant[i]);
            if (if_ack) exp_if.push_back(32'hDEADBEEF);
            if (lsu_ack) exp_lsu.push_back(32'h80345678);
            step();
        end
        if_req = 1'b0; lsu_req = 1'b0;
        step();
        step();

`ifndef MEM_ARB_LSU_PRIORITY_EN
        lsu_op(0, 2'b11, 0, 32'h300, 0, 32'h11223344);
        step();
        if_req = 1'b1; if_addr = 32'h100;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_len = 2'b11; lsu_addr = 32'h100;
        @(negedge clk);
        check("drop_if_wins", {if_ack, lsu_ack}, 2'b10);
        if (if_ack) exp_if.push_back(32'hDEADBEEF);
        step();
        if_req = 1'b0; lsu_req = 1'b0;
        @(negedge clk);
        check("drop_no_ack", lsu_ack, 0);
        step();
        lsu_req = 1'b1;
        @(negedge clk);
        check("reassert_ack", lsu_ack, 1);
        if (lsu_ack) exp_lsu.push_back(32'hDEADBEEF);
        step();
        lsu_req = 1'b0;
        step();
        step();
        @(negedge clk);
        check("if_rdata_hold", if_rdata, 32'hDEADBEEF);
        check("lsu_rdata_hold", lsu_rdata, 32'hDEADBEEF);
`endif
        check("exp_if_drained", exp_if.size(), 0);
        check("exp_lsu_drained", exp_lsu.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
